// File: rtl/uart_loopback_ctrl.sv
// uart_loopback_ctrl: pops RX FIFO words, transforms them by mode, pushes to TX FIFO under tx_full backpressure, latches leds, counts words
module uart_loopback_ctrl #(
  parameter int N_BIT = 8,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [1:0]       mode,
  input  logic             rx_empty,
  input  logic [N_BIT-1:0] r_data,
  output logic             rd_uart,
  input  logic             tx_full,
  output logic [N_BIT-1:0] w_data,
  output logic             wr_uart,
  output logic [N_BIT-1:0] leds,
  output logic [CNT_W-1:0] rx_cnt,
  output logic [CNT_W-1:0] tx_cnt,
  output logic             stall
);
  typedef enum logic [1:0] {IDLE, POP, SEND, PUSH} state_t;
  state_t           state;
  logic [N_BIT-1:0] hold;
  logic [N_BIT-1:0] xf;
  logic             mon;
  always_comb xf = mode == 2'b01 ? ~r_data : mode == 2'b10 ? r_data + N_BIT'(1) : r_data;
  always_ff @(posedge CLK)
    if (RESET) begin
      state   <= IDLE;
      hold    <= '0;
      mon     <= 1'b0;
      rd_uart <= 1'b0;
      wr_uart <= 1'b0;
      stall   <= 1'b0;
      w_data  <= '0;
      leds    <= '0;
      rx_cnt  <= '0;
      tx_cnt  <= '0;
    end else
      case (state)
        IDLE:
          if (!rx_empty) begin
            hold    <= xf;
            leds    <= r_data;
            mon     <= mode == 2'b11;
            rd_uart <= 1'b1;
            rx_cnt  <= rx_cnt + CNT_W'(~&rx_cnt);
            state   <= POP;
          end
        POP: begin
          rd_uart <= 1'b0;
          state   <= mon ? IDLE : SEND;
        end
        SEND:
          if (tx_full)
            stall <= 1'b1;
          else begin
            w_data  <= hold;
            wr_uart <= 1'b1;
            stall   <= 1'b0;
            state   <= PUSH;
          end
        PUSH: begin
          wr_uart <= 1'b0;
          tx_cnt  <= tx_cnt + CNT_W'(~&tx_cnt);
          state   <= IDLE;
        end
      endcase
endmodule

// File: tb/tb_uart_loopback_ctrl.sv
// tb_uart_loopback_ctrl: scoreboard bench driving a modelled RX FIFO and checking TX pushes, counters, stall and timing
module tb_uart_loopback_ctrl;
  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [1:0]  mode = 2'b00;
  logic        rx_empty = 1'b1;
  logic [7:0]  r_data = 8'h00;
  logic        tx_full = 1'b0;
  logic        rd_uart, wr_uart, stall;
  logic [7:0]  w_data, leds;
  logic [15:0] rx_cnt, tx_cnt;
  logic        rd2, wr2, stall2;
  logic [7:0]  w_data2, leds2;
  logic [1:0]  rx_cnt2, tx_cnt2;
  logic [7:0]  rx_q[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];
  int          wr_cyc_q[$];
  int          rd_cyc_q[$];
  int          cyc = 0, rd_count = 0, wr_count = 0, last_rd = 0, last_wr = 0;
  int          overlap = 0, divergent = 0;
  int          exp_rx = 0, exp_tx = 0;
  int          n_cmp = 0, n_bad = 0;

  uart_loopback_ctrl #(.N_BIT(8), .CNT_W(16)) dut (
    .CLK(CLK), .RESET(RESET), .mode(mode), .rx_empty(rx_empty), .r_data(r_data),
    .rd_uart(rd_uart), .tx_full(tx_full), .w_data(w_data), .wr_uart(wr_uart),
    .leds(leds), .rx_cnt(rx_cnt), .tx_cnt(tx_cnt), .stall(stall)
  );

  uart_loopback_ctrl #(.N_BIT(8), .CNT_W(2)) dut2 (
    .CLK(CLK), .RESET(RESET), .mode(mode), .rx_empty(rx_empty), .r_data(r_data),
    .rd_uart(rd2), .tx_full(tx_full), .w_data(w_data2), .wr_uart(wr2),
    .leds(leds2), .rx_cnt(rx_cnt2), .tx_cnt(tx_cnt2), .stall(stall2)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    cyc++;
    if (rd_uart) begin
      rd_count++;
      last_rd = cyc;
      rd_cyc_q.push_back(cyc);
      if (rx_q.size() > 0) rx_q.delete(0);
    end
    if (wr_uart) begin
      wr_count++;
      last_wr = cyc;
      got_q.push_back(w_data);
      wr_cyc_q.push_back(cyc);
    end
    if (rd_uart && wr_uart) overlap++;
    if ({rd_uart, wr_uart, stall, w_data, leds} !== {rd2, wr2, stall2, w_data2, leds2}) divergent++;
    rx_empty = rx_q.size() == 0;
    r_data = rx_q.size() > 0 ? rx_q[0] : 8'h00;
  end

  function automatic logic [7:0] xform(input logic [7:0] x, input logic [1:0] m);
    logic [7:0] r;
    r = x;
    if (m == 2'b01) r = ~x;
    if (m == 2'b10) r = x + 8'd1;
    return r;
  endfunction

  function automatic int sat3(input int v);
    return v > 3 ? 3 : v;
  endfunction

  task automatic push_word(input logic [7:0] b);
    rx_q.push_back(b);
    exp_rx++;
    if (mode != 2'b11) begin
      exp_q.push_back(xform(b, mode));
      exp_tx++;
    end
  endtask

  task automatic wait_drain(output bit timed_out);
    int n;
    n = 0;
    while ((rx_q.size() != 0 || got_q.size() < exp_q.size()) && n < 400) begin
      @(posedge CLK);
      n++;
    end
    repeat (6) @(posedge CLK);
    #1;
    timed_out = n >= 400;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge CLK);
    #1;
    n_cmp++;
    if ({rd_uart, wr_uart, stall, w_data, leds, rx_cnt, tx_cnt} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h required 0", {rd_uart, wr_uart, stall, w_data, leds, rx_cnt, tx_cnt});
    end
    n_cmp++;
    if ({rd2, wr2, stall2, w_data2, leds2, rx_cnt2, tx_cnt2} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs_cnt2: got %h required 0", {rd2, wr2, stall2, w_data2, leds2, rx_cnt2, tx_cnt2});
    end
    RESET = 1'b0;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_echo_latency();
    bit to;
    logic [7:0] e, g;
    mode = 2'b00;
    push_word(8'h41);
    wait_drain(to);
    n_cmp++;
    if (to) begin n_bad++; $display("FAIL echo_timeout: got timeout required drain"); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (got_q.size() == 0) begin n_bad++; $display("FAIL echo_word: got none required %h", e); end
      else begin
        g = got_q.pop_front();
        if (g !== e) begin n_bad++; $display("FAIL echo_word: got %h required %h", g, e); end
      end
    end
    n_cmp++;
    if (last_wr - last_rd != 2) begin n_bad++; $display("FAIL echo_latency: got %0d required 2", last_wr - last_rd); end
    n_cmp++;
    if (leds !== 8'h41) begin n_bad++; $display("FAIL echo_leds: got %h required 41", leds); end
    n_cmp++;
    if (rx_cnt !== 16'(exp_rx) || tx_cnt !== 16'(exp_tx)) begin
      n_bad++;
      $display("FAIL echo_counts: got %0d/%0d required %0d/%0d", rx_cnt, tx_cnt, exp_rx, exp_tx);
    end
  endtask

  task automatic test_transforms();
    bit to;
    logic [7:0] e, g;
    mode = 2'b01;
    push_word(8'h0F);
    wait_drain(to);
    mode = 2'b10;
    push_word(8'hFF);
    push_word(8'h7F);
    wait_drain(to);
    n_cmp++;
    if (to) begin n_bad++; $display("FAIL xform_timeout: got timeout required drain"); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (got_q.size() == 0) begin n_bad++; $display("FAIL xform_word: got none required %h", e); end
      else begin
        g = got_q.pop_front();
        if (g !== e) begin n_bad++; $display("FAIL xform_word: got %h required %h", g, e); end
      end
    end
    n_cmp++;
    if (leds !== 8'h7F) begin n_bad++; $display("FAIL xform_leds: got %h required 7f", leds); end
    mode = 2'b00;
  endtask

  task automatic test_monitor();
    bit to;
    int wr0;
    wr0 = wr_count;
    rd_cyc_q.delete();
    mode = 2'b11;
    push_word(8'h11);
    push_word(8'h22);
    wait_drain(to);
    n_cmp++;
    if (wr_count != wr0 || got_q.size() != 0) begin
      n_bad++;
      $display("FAIL monitor_no_push: got %0d pushes required 0", wr_count - wr0);
    end
    n_cmp++;
    if (leds !== 8'h22) begin n_bad++; $display("FAIL monitor_leds: got %h required 22", leds); end
    n_cmp++;
    if (rx_cnt !== 16'(exp_rx) || tx_cnt !== 16'(exp_tx)) begin
      n_bad++;
      $display("FAIL monitor_counts: got %0d/%0d required %0d/%0d", rx_cnt, tx_cnt, exp_rx, exp_tx);
    end
    n_cmp++;
    if (rd_cyc_q.size() != 2 || rd_cyc_q[1] - rd_cyc_q[0] != 2) begin
      n_bad++;
      $display("FAIL monitor_spacing: got %0d pops required 2 pops 2 cycles apart", rd_cyc_q.size());
    end
    mode = 2'b00;
  endtask

  task automatic test_stall();
    bit to;
    int rd0, wr0;
    logic [7:0] e, g;
    rd0 = rd_count;
    wr0 = wr_count;
    mode = 2'b00;
    tx_full = 1'b1;
    push_word(8'h55);
    push_word(8'h66);
    repeat (10) @(posedge CLK);
    #1;
    n_cmp++;
    if (stall !== 1'b1) begin n_bad++; $display("FAIL stall_high: got %b required 1", stall); end
    n_cmp++;
    if (wr_count != wr0) begin n_bad++; $display("FAIL stall_no_push: got %0d required 0", wr_count - wr0); end
    n_cmp++;
    if (rd_count != rd0 + 1) begin n_bad++; $display("FAIL stall_one_pop: got %0d required 1", rd_count - rd0); end
    tx_full = 1'b0;
    wait_drain(to);
    n_cmp++;
    if (to) begin n_bad++; $display("FAIL stall_timeout: got timeout required drain"); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (got_q.size() == 0) begin n_bad++; $display("FAIL stall_word: got none required %h", e); end
      else begin
        g = got_q.pop_front();
        if (g !== e) begin n_bad++; $display("FAIL stall_word: got %h required %h", g, e); end
      end
    end
    n_cmp++;
    if (stall !== 1'b0) begin n_bad++; $display("FAIL stall_low: got %b required 0", stall); end
  endtask

  task automatic test_reset_in_send();
    bit to;
    int rd0, wr0, n;
    logic [7:0] e, g;
    mode = 2'b00;
    tx_full = 1'b1;
    push_word(8'h77);
    repeat (8) @(posedge CLK);
    #1;
    n_cmp++;
    if (stall !== 1'b1) begin n_bad++; $display("FAIL rst_send_stall: got %b required 1", stall); end
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    void'(exp_q.pop_back());
    exp_rx = 0;
    exp_tx = 0;
    n_cmp++;
    if ({rd_uart, wr_uart, stall, w_data, leds, rx_cnt, tx_cnt} !== '0) begin
      n_bad++;
      $display("FAIL rst_send_outputs: got %h required 0", {rd_uart, wr_uart, stall, w_data, leds, rx_cnt, tx_cnt});
    end
    rd0 = rd_count;
    wr0 = wr_count;
    tx_full = 1'b0;
    repeat (8) @(posedge CLK);
    #1;
    n_cmp++;
    if (wr_count != wr0 || rd_count != rd0) begin
      n_bad++;
      $display("FAIL rst_send_no_pulse: got %0d/%0d pulses required 0/0", rd_count - rd0, wr_count - wr0);
    end
    mode = 2'b01;
    push_word(8'h3C);
    n = 0;
    while (rd_uart !== 1'b1 && n < 50) begin
      @(posedge CLK);
      #1;
      n++;
    end
    mode = 2'b10;
    wait_drain(to);
    n_cmp++;
    if (to || n >= 50) begin n_bad++; $display("FAIL mode_change_timeout: got timeout required drain"); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (got_q.size() == 0) begin n_bad++; $display("FAIL mode_change_word: got none required %h", e); end
      else begin
        g = got_q.pop_front();
        if (g !== e) begin n_bad++; $display("FAIL mode_change_word: got %h required %h", g, e); end
      end
    end
    mode = 2'b00;
  endtask

  task automatic test_saturation();
    bit to;
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    exp_rx = 0;
    exp_tx = 0;
    mode = 2'b00;
    for (int i = 0; i < 5; i++) begin
      push_word(8'(8'hA0 + i));
      wait_drain(to);
    end
    got_q.delete();
    exp_q.delete();
    n_cmp++;
    if (rx_cnt !== 16'(exp_rx) || tx_cnt !== 16'(exp_tx)) begin
      n_bad++;
      $display("FAIL sat_wide_counts: got %0d/%0d required %0d/%0d", rx_cnt, tx_cnt, exp_rx, exp_tx);
    end
    n_cmp++;
    if (rx_cnt2 !== 2'(sat3(exp_rx)) || tx_cnt2 !== 2'(sat3(exp_tx))) begin
      n_bad++;
      $display("FAIL sat_counts: got %0d/%0d required %0d/%0d", rx_cnt2, tx_cnt2, sat3(exp_rx), sat3(exp_tx));
    end
  endtask

  task automatic test_back_to_back();
    bit to;
    logic [7:0] e, g;
    mode = 2'b00;
    wr_cyc_q.delete();
    for (int i = 0; i < 8; i++) push_word(8'(i * 8'h21 + 8'h03));
    wait_drain(to);
    n_cmp++;
    if (to) begin n_bad++; $display("FAIL b2b_timeout: got timeout required drain"); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (got_q.size() == 0) begin n_bad++; $display("FAIL b2b_word: got none required %h", e); end
      else begin
        g = got_q.pop_front();
        if (g !== e) begin n_bad++; $display("FAIL b2b_word: got %h required %h", g, e); end
      end
    end
    n_cmp++;
    if (wr_cyc_q.size() != 8) begin n_bad++; $display("FAIL b2b_count: got %0d required 8", wr_cyc_q.size()); end
    for (int i = 1; i < wr_cyc_q.size(); i++) begin
      n_cmp++;
      if (wr_cyc_q[i] - wr_cyc_q[i-1] != 4) begin
        n_bad++;
        $display("FAIL b2b_spacing: got %0d required 4", wr_cyc_q[i] - wr_cyc_q[i-1]);
      end
    end
    n_cmp++;
    if (rx_cnt2 !== 2'd3 || tx_cnt2 !== 2'd3) begin
      n_bad++;
      $display("FAIL b2b_sat_hold: got %0d/%0d required 3/3", rx_cnt2, tx_cnt2);
    end
  endtask

  initial begin
    test_reset();
    test_echo_latency();
    test_transforms();
    test_monitor();
    test_stall();
    test_reset_in_send();
    test_saturation();
    test_back_to_back();
    n_cmp++;
    if (overlap != 0) begin n_bad++; $display("FAIL rd_wr_overlap: got %0d required 0", overlap); end
    n_cmp++;
    if (divergent != 0) begin n_bad++; $display("FAIL width_instances_agree: got %0d differing cycles required 0", divergent); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
